// File: rtl/opc2x_cpu.sv
// ---------------------------------------------------------------------------
// opc2x_cpu -- small 8-bit accumulator CPU with an AW-bit byte address bus.
//
// Registers: ACC, B, carry C, zero Z, program counter PC, instruction
// register IR and an AW-bit operand register that doubles as the pointer
// for the indirect addressing modes.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset_b    asynchronous active-low reset
//   mem_ready  bus handshake; 0 stalls the current bus cycle
//   address    byte address (operand during data cycles, else PC)
//   rnw        1 = read, 0 = write (only during STA/STAP execute)
//   data       bidirectional data bus; ACC is driven only while writing
//   halted     1 once HALT has been fetched, held until reset
// ---------------------------------------------------------------------------
module opc2x_cpu #(
  parameter int unsigned   AW       = 10,
  parameter logic [AW-1:0] RESET_PC = AW'('h100)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          mem_ready,
  output logic [AW-1:0] address,
  output logic          rnw,
  inout  wire  [7:0]    data,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_FETCH0, S_FETCH1, S_RDMEM, S_RDMEM2, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADC  = 4'h0, OP_NOT  = 4'h1, OP_AND  = 4'h2, OP_AXB  = 4'h3,
    OP_JPC  = 4'h4, OP_JPZ  = 4'h5, OP_STA  = 4'h6, OP_JAL  = 4'h7,
    OP_LDBI = 4'h8, OP_LDB  = 4'h9, OP_STAP = 4'hA, OP_LDA  = 4'hB,
    OP_LDBP = 4'hC, OP_LDAP = 4'hD, OP_NOP  = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  state_t        r_state;
  opcode_t       r_ir;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_operand;
  logic [7:0]    r_acc;
  logic [7:0]    r_b;
  logic          r_c;
  logic          r_z;
  logic          r_halted;

  logic [7:0]    w_din;
  logic          w_store;
  logic          w_needs_rdmem;
  logic [8:0]    w_sum;
  logic [15:0]   w_link;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_jal_target;
  logic [AW-1:0] w_rd_operand;

  assign w_din = data;

  // Only STA and STAP touch memory in their execute cycle.
  assign w_store = (r_state == S_EXEC) && ((r_ir == OP_STA) || (r_ir == OP_STAP));

  // Loads and STAP need at least one data read; LDBI and NOP carry an
  // immediate that is never dereferenced.
  assign w_needs_rdmem = r_ir[3] && (r_ir != OP_LDBI) && (r_ir != OP_NOP);

  assign w_sum        = {1'b0, r_acc} + {1'b0, r_b} + {8'h00, r_c};
  assign w_link       = 16'(r_pc);
  assign w_pc_inc     = r_pc + AW'(1);
  assign w_jal_target = {r_b[AW-9:0], r_acc};
  // A byte read from memory is always a page-zero pointer or a data value.
  assign w_rd_operand = {{(AW-8){1'b0}}, w_din};

  assign address = ((r_state == S_RDMEM) || (r_state == S_RDMEM2) || w_store)
                   ? r_operand : r_pc;
  // Gating with reset_b makes the bus return to read the instant reset
  // asserts, so an aborted write can never complete.
  assign rnw     = ~(w_store & reset_b);
  assign data    = rnw ? 8'hzz : r_acc;
  assign halted  = r_halted;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      // NOTE: every architectural register sits in the async reset branch;
      // nothing is left to power-up state, so a reset mid-instruction
      // cannot leave a partially updated register behind.
      r_state   <= S_FETCH0;
      r_ir      <= OP_ADC;
      r_pc      <= RESET_PC;
      r_operand <= '0;
      r_acc     <= 8'h00;
      r_b       <= 8'h00;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_halted  <= 1'b0;
    end else if (r_state == S_HALT) begin
      // Terminal until reset; mem_ready is irrelevant here.
      r_halted <= 1'b1;
    end else if (mem_ready) begin
      case (r_state)
        S_FETCH0: begin
          r_ir                <= opcode_t'(w_din[7:4]);
          r_operand[AW-1:8]   <= w_din[AW-9:0];
          r_pc                <= w_pc_inc;
          r_state             <= (w_din[7:6] != 2'b00) ? S_FETCH1 : S_EXEC;
        end
        S_FETCH1: begin
          r_operand[7:0] <= w_din;
          r_pc           <= w_pc_inc;
          if (r_ir == OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_needs_rdmem) begin
            r_state <= S_RDMEM;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_RDMEM: begin
          r_operand <= w_rd_operand;
          r_state   <= r_ir[2] ? S_RDMEM2 : S_EXEC;
        end
        S_RDMEM2: begin
          r_operand <= w_rd_operand;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH0;
          case (r_ir)
            OP_ADC: begin
              {r_c, r_acc} <= w_sum;
              r_z          <= (w_sum[7:0] == 8'h00);
            end
            OP_NOT: begin
              r_acc <= ~r_acc;
              r_z   <= (~r_acc == 8'h00);
            end
            OP_AND: begin
              r_acc <= r_acc & r_b;
              r_c   <= 1'b0;
              r_z   <= ((r_acc & r_b) == 8'h00);
            end
            OP_AXB: begin
              // NOTE: non-blocking assignments read the pre-edge values, so
              // the two lines below are a true swap with no temporary.
              r_acc <= r_b;
              r_b   <= r_acc;
              r_z   <= (r_b == 8'h00);
            end
            OP_JPC: if (r_c) r_pc <= r_operand;
            OP_JPZ: if (r_z) r_pc <= r_operand;
            OP_JAL: begin
              r_pc         <= w_jal_target;
              {r_b, r_acc} <= w_link;
              r_z          <= (w_link[7:0] == 8'h00);
            end
            OP_LDBI, OP_LDB, OP_LDBP: r_b <= r_operand[7:0];
            OP_LDA, OP_LDAP: begin
              r_acc <= r_operand[7:0];
              r_z   <= (r_operand[7:0] == 8'h00);
            end
            default: ; // STA, STAP, NOP: only the bus activity / PC advance
          endcase
        end
        default: r_state <= S_FETCH0;
      endcase
    end
  end

endmodule
